// File: rtl/pipelined_arith_datapath.sv
// Registered valid/ready datapath computing a*b + a + b with configurable depth and overflow flag.
// Define ARITH_SAT_EN to clamp out-of-range results to all ones instead of wrapping.
module pipelined_arith_datapath #(
    parameter int WIDTH  = 4,
    parameter int RES_W  = 8,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] result,
    output logic             ovf
);

    localparam int FW = 2 * WIDTH;
    // Index of the stage that produces the full-precision value, and the count of result registers from there on.
    localparam int unsigned RS = (STAGES == 2) ? 1 : 2;
    localparam int unsigned NR = STAGES - RS;
    localparam logic [FW:0] LIM = (FW + 1)'(1) << RES_W;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic              accept;
    logic [WIDTH-1:0]  a1;
    logic [WIDTH-1:0]  b1;
    logic [FW-1:0]     full_d;
    logic [RES_W-1:0]  res_d;
    logic              ovf_d;
    logic [RES_W-1:0]  res_pipe [NR];
    logic [NR-1:0]     ovf_pipe;

    // A stage may advance when it or any stage downstream of it is empty, or the sink takes the output.
    genvar gk;
    for (gk = 0; gk < STAGES; gk++) begin : g_ready
        assign adv[gk] = out_ready || !(&v[STAGES-1:gk]);
    end

    assign in_ready = adv[0] && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else if (flush) begin
            v <= '0;
        end else begin
            if (adv[0]) v[0] <= accept;
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (adv[k]) v[k] <= v[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1 <= '0;
            b1 <= '0;
        end else if (accept) begin
            a1 <= a;
            b1 <= b;
        end
    end

    if (STAGES == 2) begin : g_direct
        assign full_d = FW'(a1) * FW'(b1) + FW'(a1) + FW'(b1);
    end else begin : g_split
        logic [FW-1:0]  prod2;
        logic [WIDTH:0] sum2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prod2 <= '0;
                sum2  <= '0;
            end else if (adv[1] && v[0]) begin
                prod2 <= FW'(a1) * FW'(b1);
                sum2  <= (WIDTH + 1)'(a1) + (WIDTH + 1)'(b1);
            end
        end

        assign full_d = prod2 + FW'(sum2);
    end

    always_comb begin
        ovf_d = ({1'b0, full_d} >= LIM);
`ifdef ARITH_SAT_EN
        res_d = ovf_d ? '1 : full_d[RES_W-1:0];
`else
        res_d = full_d[RES_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < NR; j++) res_pipe[j] <= '0;
            ovf_pipe <= '0;
        end else if (flush) begin
            for (int unsigned j = 0; j < NR; j++) res_pipe[j] <= '0;
            ovf_pipe <= '0;
        end else begin
            if (adv[RS] && v[RS-1]) begin
                res_pipe[0] <= res_d;
                ovf_pipe[0] <= ovf_d;
            end
            for (int unsigned j = 1; j < NR; j++) begin
                if (adv[RS+j] && v[RS+j-1]) begin
                    res_pipe[j] <= res_pipe[j-1];
                    ovf_pipe[j] <= ovf_pipe[j-1];
                end
            end
        end
    end

    assign out_valid = v[STAGES-1];
    assign result    = res_pipe[NR-1];
    assign ovf       = ovf_pipe[NR-1];

endmodule

// File: tb/tb_pipelined_arith_datapath.sv
// Directed bench for pipelined_arith_datapath: default build plus a RES_W=6 copy for overflow cases.
module tb_pipelined_arith_datapath;

    localparam int STAGES = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] result;
    logic       ovf;
    logic       in_ready6;
    logic       out_valid6;
    logic [5:0] result6;
    logic       ovf6;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_n = 0;
    int idx;
    int q_res[$];
    int q_ovf[$];
    int q_cyc[$];
    int q6_res[$];
    int q6_ovf[$];

    logic [3:0] t3_a [6] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    logic [3:0] t3_b [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    int         t3_r [6] = '{5, 11, 19, 29, 41, 55};

`ifdef ARITH_SAT_EN
    localparam int OVF6_RES = 32'h3F;
`else
    localparam int OVF6_RES = 32'h10;
`endif

    always #5 clk = ~clk;

    pipelined_arith_datapath #(.WIDTH(4), .RES_W(8), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf)
    );

    pipelined_arith_datapath #(.WIDTH(4), .RES_W(6), .STAGES(STAGES)) dut6 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready6), .a(a), .b(b),
        .out_valid(out_valid6), .out_ready(out_ready), .result(result6), .ovf(ovf6)
    );

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Output transfers are recorded mid-cycle; a flushed output does not count as transferred.
    always @(negedge clk) begin
        if (rst_n && !flush && out_ready) begin
            if (out_valid) begin
                q_res.push_back(int'(result));
                q_ovf.push_back(int'(ovf));
                q_cyc.push_back(cyc_n);
            end
            if (out_valid6) begin
                q6_res.push_back(int'(result6));
                q6_ovf.push_back(int'(ovf6));
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q;
        q_res.delete();
        q_ovf.delete();
        q_cyc.delete();
        q6_res.delete();
        q6_ovf.delete();
    endtask

    task automatic latency_item(input string tag, input logic [3:0] ia, input logic [3:0] ib,
                                input logic [7:0] exp);
        step;
        a = ia;
        b = ib;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_accept"}, in_ready, 1);
        for (int e = 1; e <= STAGES; e++) begin
            step;
            in_valid = 1'b0;
            @(negedge clk);
            check({tag, "_valid"}, out_valid, (e == STAGES));
        end
        check({tag, "_result"}, result, exp);
        check({tag, "_ovf"}, ovf, 0);
        step;
        @(negedge clk);
        check({tag, "_valid_after"}, out_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_ovf", ovf, 0);
        step;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        latency_item("t1", 4'd3, 4'd5, 8'h17);

        // Back-to-back stream a=b=i
        clear_q();
        for (int i = 0; i < 16; i++) begin
            step;
            a = 4'(i);
            b = 4'(i);
            in_valid = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            check("t2_in_ready", in_ready, 1);
        end
        step;
        in_valid = 1'b0;
        repeat (STAGES + 2) step;
        check("t2_count", q_res.size(), 16);
        for (int i = 0; i < 16 && i < q_res.size(); i++) begin
            check("t2_result", q_res[i], i * i + 2 * i);
            check("t2_ovf", q_ovf[i], 0);
        end
        if (q_cyc.size() == 16) check("t2_gapless", q_cyc[15] - q_cyc[0], 15);

        // Six items against an 8-cycle output stall
        clear_q();
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            step;
            out_ready = 1'b0;
            in_valid = (idx < 6);
            a = t3_a[(idx < 6) ? idx : 5];
            b = t3_b[(idx < 6) ? idx : 5];
            @(negedge clk);
            check("t3_stall_ready", in_ready, (c < 3));
            if (c >= 3) begin
                check("t3_hold_valid", out_valid, 1);
                check("t3_hold_result", result, t3_r[0]);
            end
            if (in_valid && in_ready) idx++;
        end
        check("t3_accepts_stalled", idx, 3);
        for (int c = 0; c < 20 && idx < 6; c++) begin
            step;
            out_ready = 1'b1;
            in_valid = 1'b1;
            a = t3_a[idx];
            b = t3_b[idx];
            @(negedge clk);
            if (in_ready) idx++;
        end
        step;
        in_valid = 1'b0;
        repeat (8) step;
        check("t3_accepts", idx, 6);
        check("t3_count", q_res.size(), 6);
        for (int i = 0; i < 6 && i < q_res.size(); i++) check("t3_result", q_res[i], t3_r[i]);
        if (q_cyc.size() == 6) check("t3_gapless", q_cyc[5] - q_cyc[0], 5);

        // Overflow on the RES_W=6 copy
        clear_q();
        step;
        out_ready = 1'b1;
        a = 4'd8;
        b = 4'd8;
        in_valid = 1'b1;
        @(negedge clk);
        check("t4_ready6", in_ready6, 1);
        step;
        a = 4'd2;
        b = 4'd3;
        step;
        in_valid = 1'b0;
        repeat (5) step;
        check("t4_count6", q6_res.size(), 2);
        check("t4_count8", q_res.size(), 2);
        if (q6_res.size() == 2) begin
            check("t4_ovf_result6", q6_res[0], OVF6_RES);
            check("t4_ovf_flag6", q6_ovf[0], 1);
            check("t4_small_result6", q6_res[1], 32'h0B);
            check("t4_small_flag6", q6_ovf[1], 0);
        end
        if (q_res.size() == 2) begin
            check("t4_result8", q_res[0], 32'h50);
            check("t4_flag8", q_ovf[0], 0);
            check("t4_small_result8", q_res[1], 32'h0B);
        end

        // Asynchronous reset with two items in flight
        clear_q();
        step;
        out_ready = 1'b0;
        a = 4'd1;
        b = 4'd1;
        in_valid = 1'b1;
        step;
        a = 4'd1;
        b = 4'd2;
        step;
        in_valid = 1'b0;
        step;
        #2;
        check("t5_pre_valid", out_valid, 1);
        check("t5_pre_result", result, 3);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_result", result, 0);
        check("t5_rst_ovf", ovf, 0);
        #3;
        rst_n = 1'b1;
        step;
        out_ready = 1'b1;
        repeat (6) step;
        check("t5_no_output", q_res.size(), 0);
        latency_item("t5", 4'd4, 4'd4, 8'h18);

        // Flush with three items in flight and a concurrent offer
        clear_q();
        step;
        out_ready = 1'b1;
        a = 4'd3;
        b = 4'd3;
        in_valid = 1'b1;
        step;
        a = 4'd2;
        b = 4'd2;
        step;
        a = 4'd1;
        b = 4'd1;
        step;
        flush = 1'b1;
        a = 4'd5;
        b = 4'd5;
        @(negedge clk);
        check("t6_flush_ready", in_ready, 0);
        check("t6_pre_valid", out_valid, 1);
        step;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("t6_valid", out_valid, 0);
        check("t6_result", result, 0);
        check("t6_ovf", ovf, 0);
        repeat (5) step;
        check("t6_no_output", q_res.size(), 0);
        latency_item("t6", 4'd6, 4'd2, 8'h14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_arith_datapath.md
Name: pipelined_arith_datapath

Overview:
Parametrised, fully registered arithmetic datapath computing result = a*b + a + b on a valid/ready stream. It is the timing-closure successor of our fixed 3-register switch pipeline. It has configurable operand width, result width and pipeline depth, per-stage backpressure, a synchronous flush and overflow reporting. It sits between board-I/O synchronisers and display or result registers in the timing test designs.

Parameters:
WIDTH, 4, operand width in bits (>=1)
RES_W, 8, result width in bits (1..2*WIDTH)
STAGES, 3, pipeline register stages from input accept to output (>=2)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all in-flight data
in_valid  input  1  a/b valid
in_ready  output  1  block can accept a/b this cycle
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
out_valid  output  1  result/ovf valid
out_ready  input  1  downstream accepts result this cycle
result  output  RES_W  computed value
ovf  output  1  full-precision value did not fit in RES_W

Behaviour:
- Reset: async assert clears every stage valid bit and data register. out_valid=0, result=0, ovf=0. in_ready is 1 one cycle after release (combinational from empty stages). In-flight items are discarded. No output is ever produced for data accepted before reset.
- Arithmetic: full = a*b + a + b, unsigned, in 2*WIDTH bits. It never exceeds 2^(2*WIDTH)-1, so there is no internal overflow.
- ovf = 1 when full >= 2^RES_W.
- result = full[RES_W-1:0] (wrap) unless the optional feature is enabled.
- Stage 1 registers a and b. Stage 2 registers the product and a+b. Stage 3 registers full. Stages 4..STAGES are pure retiming registers.
- If STAGES=2, stage 2 computes full directly from the stage-1 registers.
- The final stage drives result/ovf/out_valid straight from flops. There is no combinational path from a/b to outputs.
- Handshake: transfer in when in_valid && in_ready. Transfer out when out_valid && out_ready.
- Stage k advances when its own valid=0 or stage k+1 advances. The last stage advances when out_valid=0 or out_ready=1.
- in_ready = stage-1 advance condition. The ready chain is combinational across stages.
- Latency: with no stall, out_valid rises exactly STAGES cycles after the accepting edge.
- Throughput: one item per cycle.
- Capacity: STAGES items. Bubbles collapse, so a stalled output lets upstream empty stages keep filling.
- While out_valid=1 and out_ready=0, result and ovf hold stable. Order is always preserved, with no loss and no duplication.
- in_valid may drop without an accept. a/b are sampled only on accept.
- flush: on the clock edge with flush=1, all valid bits are cleared and in_ready is forced to 0 that cycle. An input offered concurrently is not accepted. Data registers may hold stale values, but result and ovf are zeroed.
- flush and out_ready both high: the output is considered not transferred.

Optional Feature:
Macro ARITH_SAT_EN.
- Defined: when ovf=1, result = all ones (2^RES_W-1); otherwise result = full. ovf behaviour is unchanged.
- Undefined: result always wraps (low RES_W bits). ovf is still reported.
- The clamp is applied in the stage that computes full, so latency is identical in both builds.

Test Plan:
- Default params, reset released, a=3 b=5 with in_valid for one cycle, out_ready=1 -> out_valid exactly 3 cycles later, result=0x17, ovf=0; out_valid low the next cycle.
- Stream a=b=0..15 back-to-back, out_ready=1 -> 16 consecutive out_valid cycles in order. The last is a=b=15 -> result=0xFF, ovf=0. in_ready stays 1 throughout.
- Stream 6 items with out_ready held 0 for 8 cycles -> in_ready falls after 3 accepts, the first result is held stable throughout the stall, and after release all 6 emerge in order with no gaps caused by the block.
- RES_W=6, a=8 b=8 -> ovf=1. Result is 0x10 without ARITH_SAT_EN and 0x3F with it. In the same run, a=2 b=3 -> 0x0B, ovf=0 in both builds.
- Two items in flight, rst_n pulsed low mid-cycle -> out_valid=0, result=0 immediately without a clock edge. After release, nothing emerges, and a new item arrives with full STAGES latency.
- Three items in flight, flush high one cycle together with an in_valid offer -> offer not accepted, pipeline empty next cycle, zero outputs produced. The next accepted item appears after STAGES cycles.
